// File: rtl/template_search_engine_if.sv
// Frame BRAM read port seen by the template search engine.
// The engine is the master. The BRAM returns rd_data a fixed latency after the address.
interface template_search_engine_if #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned PIXEL_W = 4
);
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [PIXEL_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/template_search_engine.sv
// SAD template search over a clamped square window around the previous object centre.
// Pixels stream in raster order through a line-buffer window. The lowest-SAD centre wins.
module template_search_engine #(
  parameter int unsigned PIXEL_W      = 4,
  parameter int unsigned TEMPLATE_W   = 3,
  parameter int unsigned SEARCH_R     = 2,
  parameter int unsigned FRAME_W      = 640,
  parameter int unsigned FRAME_H      = 480,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned SCAN_W = 2 * SEARCH_R + TEMPLATE_W,
  localparam int unsigned N      = SCAN_W * SCAN_W,
  localparam int unsigned H      = (TEMPLATE_W - 1) / 2,
  localparam int unsigned SAD_W  = PIXEL_W + $clog2(TEMPLATE_W * TEMPLATE_W) + 1,
  localparam int unsigned ADDR_W = $clog2(FRAME_W * FRAME_H),
  localparam int unsigned XW     = $clog2(FRAME_W),
  localparam int unsigned YW     = $clog2(FRAME_H)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [XW-1:0]                            center_x,
  input  logic [YW-1:0]                            center_y,
  input  logic [TEMPLATE_W*TEMPLATE_W*PIXEL_W-1:0] template_flat,
  input  logic [SAD_W-1:0]                         accept_thresh,
  template_search_engine_if.master                 bram,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     found,
  output logic [XW-1:0]                            best_x,
  output logic [YW-1:0]                            best_y,
  output logic [SAD_W-1:0]                         best_sad
);

  localparam int unsigned TmplBits = TEMPLATE_W * TEMPLATE_W * PIXEL_W;
  localparam int unsigned WinLen   = (TEMPLATE_W - 1) * SCAN_W + TEMPLATE_W;
  localparam int unsigned CntW     = $clog2(SCAN_W + 1);
  localparam int unsigned ScanCntW = $clog2(N + 1);
  localparam int          MaxWx    = int'(FRAME_W) - int'(SCAN_W);
  localparam int          MaxWy    = int'(FRAME_H) - int'(SCAN_W);
  localparam int          Back     = int'(SEARCH_R + H);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(FRAME_W - SCAN_W + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StScan, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [XW-1:0]       cx_q, wx0_q, wx0_d, win_x_q, best_x_q, cand_x;
  logic [YW-1:0]       cy_q, wy0_q, wy0_d, win_y_q, best_y_q, cand_y;
  logic [TmplBits-1:0] tmpl_q;
  logic [SAD_W-1:0]    thresh_q, sad_d, sad_q, min_q, best_sad_q;
  logic [ADDR_W-1:0]   rd_addr_q, base_addr;
  logic [CntW-1:0]     sx_q, sy_q;
  logic [ScanCntW-1:0] scan_cnt_q;
  logic                scan_last, pipe_empty, cap_cand, found_q;
  int                  ox, oy;

  // Position tags ride alongside the BRAM latency so each pixel knows where it sits.
  logic [READ_LATENCY-1:0] tag_v_q;
  logic [CntW-1:0]         tag_x_q [READ_LATENCY];
  logic [CntW-1:0]         tag_y_q [READ_LATENCY];
  logic                    cap_v_q, sad_v_q, sad_cand_q;
  logic [CntW-1:0]         cap_x_q, cap_y_q;
  logic [XW-1:0]           sad_cx_q;
  logic [YW-1:0]           sad_cy_q;
  logic [PIXEL_W-1:0]      win_q [WinLen];
  logic [PIXEL_W-1:0]      tp, wp;

  assign scan_last  = (scan_cnt_q == ScanCntW'(N - 1));
  assign pipe_empty = ~(|tag_v_q) & ~cap_v_q & ~sad_v_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: state_d = StScan;
      StScan:  if (scan_last) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Window origin clamped so the whole scan area stays inside the frame.
  always_comb begin
    ox = int'(cx_q) - Back;
    oy = int'(cy_q) - Back;
    if (ox < 0) ox = 0;
    else if (ox > MaxWx) ox = MaxWx;
    if (oy < 0) oy = 0;
    else if (oy > MaxWy) oy = MaxWy;
    wx0_d     = XW'(ox);
    wy0_d     = YW'(oy);
    base_addr = ADDR_W'(oy * int'(FRAME_W) + ox);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q       <= '0;
      cy_q       <= '0;
      tmpl_q     <= '0;
      thresh_q   <= '0;
      wx0_q      <= '0;
      wy0_q      <= '0;
      rd_addr_q  <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      scan_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        cx_q     <= center_x;
        cy_q     <= center_y;
        tmpl_q   <= template_flat;
        thresh_q <= accept_thresh;
      end
      if (state_q == StSetup) begin
        wx0_q      <= wx0_d;
        wy0_q      <= wy0_d;
        rd_addr_q  <= base_addr;
        sx_q       <= '0;
        sy_q       <= '0;
        scan_cnt_q <= '0;
      end
      // The final address is left on the bus once the scan ends.
      if (state_q == StScan && !scan_last) begin
        scan_cnt_q <= scan_cnt_q + ScanCntW'(1);
        if (sx_q == CntW'(SCAN_W - 1)) begin
          sx_q      <= '0;
          sy_q      <= sy_q + CntW'(1);
          rd_addr_q <= rd_addr_q + RowStep;
        end else begin
          sx_q      <= sx_q + CntW'(1);
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q    <= '0;
      cap_v_q    <= 1'b0;
      sad_v_q    <= 1'b0;
      sad_cand_q <= 1'b0;
    end else begin
      tag_v_q[0] <= (state_q == StScan);
      for (int l = 1; l < int'(READ_LATENCY); l++) tag_v_q[l] <= tag_v_q[l-1];
      cap_v_q    <= tag_v_q[READ_LATENCY-1];
      sad_v_q    <= cap_v_q;
      sad_cand_q <= cap_cand;
    end
  end

  always_ff @(posedge clk) begin
    tag_x_q[0] <= sx_q;
    tag_y_q[0] <= sy_q;
    for (int l = 1; l < int'(READ_LATENCY); l++) begin
      tag_x_q[l] <= tag_x_q[l-1];
      tag_y_q[l] <= tag_y_q[l-1];
    end
    if (tag_v_q[READ_LATENCY-1]) begin
      win_q[0] <= bram.rd_data;
      for (int l = 1; l < int'(WinLen); l++) win_q[l] <= win_q[l-1];
    end
    cap_x_q  <= tag_x_q[READ_LATENCY-1];
    cap_y_q  <= tag_y_q[READ_LATENCY-1];
    sad_q    <= sad_d;
    sad_cx_q <= cand_x;
    sad_cy_q <= cand_y;
  end

  assign cap_cand = cap_v_q && (cap_x_q >= CntW'(TEMPLATE_W - 1))
                            && (cap_y_q >= CntW'(TEMPLATE_W - 1));
  assign cand_x   = XW'(32'(wx0_q) + 32'(cap_x_q) - H);
  assign cand_y   = YW'(32'(wy0_q) + 32'(cap_y_q) - H);

  // Newest pixel is win_q[0]; template tap [r][c] lies (T-1-r) rows and (T-1-c) pixels back.
  always_comb begin
    sad_d = '0;
    tp    = '0;
    wp    = '0;
    for (int r = 0; r < int'(TEMPLATE_W); r++) begin
      for (int c = 0; c < int'(TEMPLATE_W); c++) begin
        tp    = tmpl_q[(r * TEMPLATE_W + c) * PIXEL_W +: PIXEL_W];
        wp    = win_q[(TEMPLATE_W - 1 - r) * SCAN_W + (TEMPLATE_W - 1 - c)];
        sad_d = sad_d + ((tp > wp) ? SAD_W'(tp - wp) : SAD_W'(wp - tp));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q      <= '1;
      win_x_q    <= '0;
      win_y_q    <= '0;
      found_q    <= 1'b0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      best_sad_q <= '1;
    end else begin
      // Strict compare keeps the earliest raster-order candidate on ties.
      if (sad_cand_q && sad_q < min_q) begin
        min_q   <= sad_q;
        win_x_q <= sad_cx_q;
        win_y_q <= sad_cy_q;
      end
      if (state_q == StSetup) min_q <= '1;
      if (state_q == StDrain && pipe_empty) begin
        best_sad_q <= min_q;
        if (min_q <= thresh_q) begin
          found_q  <= 1'b1;
          best_x_q <= win_x_q;
          best_y_q <= win_y_q;
        end else begin
          found_q  <= 1'b0;
          best_x_q <= cx_q;
          best_y_q <= cy_q;
        end
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign bram.rd_en   = (state_q == StScan);
  assign bram.rd_addr = rd_addr_q;
  assign found        = found_q;
  assign best_x       = best_x_q;
  assign best_y       = best_y_q;
  assign best_sad     = best_sad_q;

endmodule

// File: tb/tb_template_search_engine.sv
// Directed bench for template_search_engine on a 16x12 frame with a one-cycle BRAM model.
module tb_template_search_engine;

  localparam int unsigned PixW = 4;
  localparam int unsigned AddrW = 8;
  localparam int unsigned SadW = 9;
  localparam int unsigned FrameW = 16;
  localparam int unsigned FrameH = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      center_x, center_y;
  logic [35:0]     template_flat;
  logic [SadW-1:0] accept_thresh;
  logic            busy, done, found;
  logic [3:0]      best_x, best_y;
  logic [SadW-1:0] best_sad;

  logic [PixW-1:0] mem [FrameW*FrameH];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int first_addr = 0;
  int last_addr  = 0;
  int lat;

  template_search_engine_if #(.ADDR_W(AddrW), .PIXEL_W(PixW)) bif ();

  template_search_engine #(
    .PIXEL_W      (PixW),
    .TEMPLATE_W   (3),
    .SEARCH_R     (2),
    .FRAME_W      (FrameW),
    .FRAME_H      (FrameH),
    .READ_LATENCY (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .center_x      (center_x),
    .center_y      (center_y),
    .template_flat (template_flat),
    .accept_thresh (accept_thresh),
    .bram          (bif.master),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .best_x        (best_x),
    .best_y        (best_y),
    .best_sad      (best_sad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bif.rd_data <= mem[bif.rd_addr];

  always @(negedge clk) begin
    if (bif.rd_en) begin
      if (rd_cnt == 0) first_addr = int'(bif.rd_addr);
      last_addr = int'(bif.rd_addr);
      rd_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] bg);
    for (int i = 0; i < int'(FrameW * FrameH); i++) mem[i] = bg;
  endtask

  // Starts a search and returns the edge count from the start-sampling edge to done.
  task automatic run_search(input logic [3:0] cx, input logic [3:0] cy, input logic [35:0] tf,
                            input logic [SadW-1:0] th, input bit extra, output int l);
    @(negedge clk);
    center_x = cx; center_y = cy; template_flat = tf; accept_thresh = th;
    rd_cnt = 0; done_cnt = 0; start = 1'b1;
    @(posedge clk);
    l = 0;
    while (l < 200) begin
      @(negedge clk);
      start = extra && (l == 10);
      center_x = 4'd0; center_y = 4'd0; template_flat = '0; accept_thresh = '0;
      if (done) break;
      @(posedge clk);
      l++;
    end
    if (extra) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; center_x = '0; center_y = '0;
    template_flat = '0; accept_thresh = '0;
    fill(4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_best_x", best_x, 0);
    check("rst_best_y", best_y, 0);
    check("rst_best_sad", best_sad, 511);
    check("rst_rd_en", bif.rd_en, 0);
    check("rst_rd_addr", bif.rd_addr, 0);

    // Block of 9s centred at (8,6).
    fill(4'd0);
    for (int y = 5; y <= 7; y++) for (int x = 7; x <= 9; x++) mem[y*FrameW + x] = 4'd9;
    run_search(4'd7, 4'd5, 36'h999999999, 9'd0, 1'b0, lat);
    check("blk_latency", lat, 54);
    check("blk_first_addr", first_addr, 36);
    check("blk_last_addr", last_addr, 138);
    check("blk_rd_cycles", rd_cnt, 49);
    check("blk_done_cnt", done_cnt, 1);
    check("blk_found", found, 1);
    check("blk_best_x", best_x, 8);
    check("blk_best_y", best_y, 6);
    check("blk_best_sad", best_sad, 0);
    check("blk_busy_after", busy, 0);

    // Low-corner clamp; the block lies outside, min SAD 81 just misses thresh 80.
    run_search(4'd1, 4'd1, 36'h999999999, 9'd80, 1'b0, lat);
    check("lo_first_addr", first_addr, 0);
    check("lo_last_addr", last_addr, 102);
    check("lo_best_sad", best_sad, 81);
    check("lo_found", found, 0);
    check("lo_best_x", best_x, 1);
    check("lo_best_y", best_y, 1);

    // High-corner clamp; three 9s in column 9 give min SAD 54 at (10,6), equal to thresh.
    run_search(4'd15, 4'd11, 36'h999999999, 9'd54, 1'b0, lat);
    check("hi_first_addr", first_addr, 89);
    check("hi_last_addr", last_addr, 191);
    check("hi_latency", lat, 54);
    check("hi_best_sad", best_sad, 54);
    check("hi_found", found, 1);
    check("hi_best_x", best_x, 10);
    check("hi_best_y", best_y, 6);

    // Every candidate ties at zero; the first centre in raster order wins.
    fill(4'd5);
    run_search(4'd7, 4'd5, 36'h555555555, 9'd0, 1'b0, lat);
    check("tie_best_sad", best_sad, 0);
    check("tie_found", found, 1);
    check("tie_best_x", best_x, 5);
    check("tie_best_y", best_y, 3);

    fill(4'd0);
    run_search(4'd7, 4'd5, 36'hFFFFFFFFF, 9'd100, 1'b0, lat);
    check("rej_best_sad", best_sad, 135);
    check("rej_found", found, 0);
    check("rej_best_x", best_x, 7);
    check("rej_best_y", best_y, 5);

    // Extra start pulses mid-scan and on the done cycle must be ignored.
    for (int y = 5; y <= 7; y++) for (int x = 7; x <= 9; x++) mem[y*FrameW + x] = 4'd9;
    run_search(4'd7, 4'd5, 36'h999999999, 9'd0, 1'b1, lat);
    repeat (60) @(negedge clk);
    check("hs_latency", lat, 54);
    check("hs_done_cnt", done_cnt, 1);
    check("hs_rd_cycles", rd_cnt, 49);
    check("hs_busy_after", busy, 0);
    check("hs_best_x", best_x, 8);

    // Reset part-way through the scan aborts the search without a done pulse.
    @(negedge clk);
    center_x = 4'd7; center_y = 4'd5; template_flat = 36'h999999999; accept_thresh = 9'd0;
    rd_cnt = 0; done_cnt = 0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_scanning", bif.rd_en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_en", bif.rd_en, 0);
    check("abort_best_sad", best_sad, 511);
    repeat (70) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    run_search(4'd7, 4'd5, 36'h999999999, 9'd0, 1'b0, lat);
    check("post_latency", lat, 54);
    check("post_first_addr", first_addr, 36);
    check("post_found", found, 1);
    check("post_best_x", best_x, 8);
    check("post_best_y", best_y, 6);
    check("post_best_sad", best_sad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/template_search_engine.md
Name: template_search_engine

Overview:
- Parametrised successor to the fixed-size correlator: SAD (sum of absolute differences) template search over a clamped square window around a given centre.
- Reads pixels from the static frame BRAM in raster order and streams them through an internal line-buffer window.
- Returns the best-matching template centre under a start/done handshake, with an acceptance threshold.
- Sits between the frame BRAM and the tracker control FSM; one search runs per frame.

Parameters:
- PIXEL_W, 4: bits per pixel.
- TEMPLATE_W, 3: template side length; must be odd and ≥3.
- SEARCH_R, 2: search radius in pixels; candidate centres span ±SEARCH_R.
- FRAME_W, 640: frame width in pixels.
- FRAME_H, 480: frame height in pixels.
- READ_LATENCY, 1: cycles from rd_en/rd_addr to valid rd_data; must be ≥1.
- Derived values, not overridable:
  - SCAN_W = 2*SEARCH_R + TEMPLATE_W
  - N = SCAN_W*SCAN_W
  - H = (TEMPLATE_W-1)/2
  - SAD_W = PIXEL_W + clog2(TEMPLATE_W*TEMPLATE_W) + 1
  - ADDR_W = clog2(FRAME_W*FRAME_H)
  - XW = clog2(FRAME_W), YW = clog2(FRAME_H)

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin a search; sampled only when busy=0.
- center_x, in, XW: previous object centre x.
- center_y, in, YW: previous object centre y.
- template_flat, in, TEMPLATE_W*TEMPLATE_W*PIXEL_W: row-major template; element [r][c] at bits (r*TEMPLATE_W+c)*PIXEL_W +: PIXEL_W.
- accept_thresh, in, SAD_W: maximum SAD accepted as a match.
- rd_en, out, 1: BRAM read strobe.
- rd_addr, out, ADDR_W: BRAM address, y*FRAME_W + x.
- rd_data, in, PIXEL_W: BRAM read data.
- busy, out, 1: high from start-accept until done.
- done, out, 1: one-cycle completion pulse.
- found, out, 1: best_sad ≤ accept_thresh; valid when done=1 and held until the next done.
- best_x, out, XW: result centre x; held.
- best_y, out, YW: result centre y; held.
- best_sad, out, SAD_W: minimum SAD found; held.

Behaviour:
- Reset values: busy=0, done=0, found=0, best_x=0, best_y=0, best_sad=all ones, rd_en=0, rd_addr=0. FSM enters IDLE.
- Reset mid-search aborts immediately: no done pulse, pipeline contents discarded.
- FSM states: IDLE → SETUP → SCAN → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 → SETUP on the next edge.
  - On the accepting edge, latch center_x, center_y, template_flat and accept_thresh into internal registers; later changes to these inputs do not affect the running search.
- SETUP (1 cycle): compute the window origin.
  - wx0 = clamp(center_x − SEARCH_R − H, 0, FRAME_W−SCAN_W).
  - wy0 is computed the same way with center_y and FRAME_H.
  - Compute with signed arithmetic; no underflow wrap.
- SCAN (exactly N cycles):
  - rd_en=1.
  - Addresses run in raster order from (wx0,wy0) to (wx0+SCAN_W−1, wy0+SCAN_W−1), x incrementing first and wrapping to wx0 at the row end.
- Data path:
  - rd_data is captured READ_LATENCY cycles after its address into a shift register of (TEMPLATE_W−1)*SCAN_W + TEMPLATE_W pixels, which forms the window.
  - A pixel at window-relative (i,j) with i,j ≥ TEMPLATE_W−1 completes a candidate with centre (wx0+i−H, wy0+j−H). Position tags travel with the data pipeline.
  - SAD = Σ|template[r][c] − window[r][c]| over all TEMPLATE_W² taps, registered once, computed unsigned in SAD_W bits (no overflow possible).
  - Compare stage: update best if the candidate SAD < current best (strict). On ties the first candidate in raster order wins.
  - The internal best register resets to all ones at SETUP.
- DRAIN: wait until the last candidate has been compared.
- DONE:
  - done=1 for one cycle.
  - Outputs update on that same edge: best_sad=min.
  - If min ≤ accept_thresh: found=1, best_x/best_y = winning centre.
  - Otherwise: found=0, best_x/best_y = latched centre.
  - busy falls with done.
- Timing: done is high exactly N + READ_LATENCY + 4 cycles after the edge that sampled start.
- start while busy=1 is ignored, including start coincident with done.
- rd_en=0 outside SCAN; rd_addr holds its last value outside SCAN.

Test Plan (TEMPLATE_W=3, PIXEL_W=4, SEARCH_R=2, FRAME 16×12, READ_LATENCY=1 → N=49; BRAM model):
- Frame all 0 except a 3×3 block of 9s centred at (8,6); template all 9; centre (7,5); thresh 0 → first rd_addr=2*16+4=36; done exactly 54 cycles after start; found=1, best=(8,6), best_sad=0.
- Edge clamping: centre (1,1) → first rd_addr=0, last=6*16+6=102. Centre (15,11) → first rd_addr=5*16+9=89, last=11*16+15=191.
- Tie-break: frame all 5, template all 5, centre (7,5) → best_sad=0, best=(5,3).
- Reject: frame all 0, template all 15, thresh 100, centre (7,5) → best_sad=135, found=0, best=(7,5).
- Handshake: start pulsed again at cycle 10 and at the done cycle → ignored, exactly one done, exactly 49 rd_en cycles.
- Reset at SCAN cycle 20 → busy=0 next cycle, no done. A new start then completes normally with correct results.
